// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg
// Shared types and helpers for the behavioural SAR ADC.
//   sar_state_t  : converter state (IDLE waiting for start, CONV resolving bits)
//   lsb_v        : voltage of one code step for a given width and reference
//   ideal_dac_v  : ideal trial-DAC output voltage for a code
package sar_adc_pkg;

    typedef enum logic {IDLE, CONV} sar_state_t;

    // One code step: VREF / 2^width.
    function automatic real lsb_v(input int width, input real vref);
        return vref / (2.0 ** width);
    endfunction

    // Ideal DAC transfer: code * LSB. Codes up to 16 bits are supported.
    function automatic real ideal_dac_v(input logic [15:0] dac_code, input int width,
                                        input real vref);
        return real'(dac_code) * lsb_v(width, vref);
    endfunction

endpackage

// File: rtl/sar_comparator.sv
// sar_comparator
// Ideal comparator between the held input and the trial DAC voltage.
// Kept as its own block so noise or hysteresis models can be dropped in later.
//   vin        : held analog input (real)
//   vref_trial : trial DAC voltage (real)
//   gt         : 1 when vin >= vref_trial + OFFSET
module sar_comparator #(
    parameter real OFFSET = 0.0
) (
    input  real  vin,
    input  real  vref_trial,
    output logic gt
);

    assign gt = (vin >= vref_trial + OFFSET);

endmodule

// File: rtl/sar_adc.sv
// sar_adc
// Behavioural successive-approximation ADC. A start request in IDLE samples
// the real input into a track-and-hold, then one bit per clock is resolved
// MSB-first against an ideal trial DAC.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   start    : conversion request, only looked at in IDLE
//   ana      : analog input voltage (real)
//   busy     : high while a conversion is running
//   done     : one-cycle pulse when code is updated
//   code     : last completed result, held until the next completion
//   trial    : current SAR trial register
//   vtrial   : ideal DAC voltage of trial (combinational)
module sar_adc
    import sar_adc_pkg::*;
#(
    parameter int  WIDTH       = 8,
    parameter real VREF        = 1.0,
    parameter real COMP_OFFSET = 0.0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  real              ana,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] code,
    output logic [WIDTH-1:0] trial,
    output real              vtrial
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY = ONE << (WIDTH - 1);

    sar_state_t       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    real              v_hold_q, v_hold_d;

    logic             gt;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial_res;

    // One-hot mask of the bit currently under test.
    assign bit_mask  = ONE << bit_idx_q;
    // Trial after this cycle's decision: the tested bit survives only if the
    // held input reached the trial voltage.
    assign trial_res = gt ? trial_q : (trial_q & ~bit_mask);

    assign vtrial = ideal_dac_v(16'(trial_q), WIDTH, VREF);

    sar_comparator #(
        .OFFSET(COMP_OFFSET)
    ) u_cmp (
        .vin       (v_hold_q),
        .vref_trial(vtrial),
        .gt        (gt)
    );

    // Next-state logic: accept in IDLE, then resolve one bit per cycle.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        code_d    = code_q;
        trial_d   = trial_q;
        bit_idx_d = bit_idx_q;
        v_hold_d  = v_hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CONV;
                    v_hold_d  = ana;
                    trial_d   = MSB_ONLY;
                    bit_idx_d = IDX_W'(WIDTH - 1);
                    busy_d    = 1'b1;
                end
            end
            CONV: begin
                if (bit_idx_q != '0) begin
                    // Keep/clear the current bit and try the next lower one.
                    trial_d   = trial_res | (bit_mask >> 1);
                    bit_idx_d = bit_idx_q - 1'b1;
                end else begin
                    code_d  = trial_res;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    trial_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset also discards any previous result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            code_q    <= '0;
            trial_q   <= '0;
            bit_idx_q <= '0;
            v_hold_q  <= 0.0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            code_q    <= code_d;
            trial_q   <= trial_d;
            bit_idx_q <= bit_idx_d;
            v_hold_q  <= v_hold_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign code  = code_q;
    assign trial = trial_q;

endmodule

// File: tb/tb_sar_adc.sv
// tb_sar_adc
// Scoreboard bench for sar_adc. Stimulus tasks push the expected code and
// accept edge into a queue; monitors pop on every done pulse and compare.
// Expected codes come from a floor/clamp model of the ideal ADC transfer.
module tb_sar_adc;

    localparam int  WIDTH = 8;
    localparam real VREF  = 1.0;
    localparam real LSB   = VREF / 256.0;
    localparam int  MAXC  = 255;

    typedef struct {
        int exp_code;
        int accept_edge;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    real              ana;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] code;
    logic [WIDTH-1:0] trial;
    real              vtrial;

    logic             start_o;
    real              ana_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] code_o;
    logic [WIDTH-1:0] trial_o;
    real              vtrial_o;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   edge_cnt = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;
    exp_t sb_q[$];
    int   sb_o[$];

    sar_adc #(.WIDTH(WIDTH), .VREF(VREF), .COMP_OFFSET(0.0)) dut (
        .clk(clk), .rst(rst), .start(start), .ana(ana), .busy(busy),
        .done(done), .code(code), .trial(trial), .vtrial(vtrial)
    );

    sar_adc #(.WIDTH(WIDTH), .VREF(VREF), .COMP_OFFSET(0.01)) dut_off (
        .clk(clk), .rst(rst), .start(start_o), .ana(ana_o), .busy(busy_o),
        .done(done_o), .code(code_o), .trial(trial_o), .vtrial(vtrial_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Ideal ADC: code = floor((v - offset) / LSB), clamped to the code range.
    function automatic int refCode(input real v, input real off);
        real x;
        x = $floor((v - off) / LSB);
        if (x < 0.0) return 0;
        if (x > real'(MAXC)) return MAXC;
        return $rtoi(x);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Start one conversion on the main DUT and record what must come back.
    task automatic applyStimulus(input real v);
        @(negedge clk);
        ana   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb_q.push_back('{refCode(v, 0.0), edge_cnt});
        checkOutput("accept_trial", int'(trial), 128);
        checkOutput("accept_vtrial_uv", $rtoi(vtrial * 1.0e6), 500000);
    endtask

    task automatic applyOffsetStimulus(input real v);
        @(negedge clk);
        ana_o   = v;
        start_o = 1'b1;
        @(negedge clk);
        start_o = 1'b0;
        sb_o.push_back(refCode(v, 0.01));
    endtask

    // Wait (bounded) for every expected result to be seen.
    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || sb_o.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", sb_q.size() + sb_o.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor for the main DUT: code, latency, pulse width and busy length.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("code", int'(code), e.exp_code);
                    checkOutput("done_edge", edge_cnt, e.accept_edge + WIDTH);
                end
                checkOutput("done_width", int'(prev_done), 0);
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                checkOutput("busy_len", busy_run, WIDTH);
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    // Monitor for the offset DUT: code only.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb_o.size() == 0) checkOutput("off_unexpected_done", 1, 0);
            else checkOutput("off_code", int'(code_o), sb_o.pop_front());
        end
    end

    real directed[7] = '{0.5, 0.49999, 0.00390625, 0.0039, 0.99609375, -0.2, 1.5};
    real ramp[6]     = '{0.1, 0.25, 0.4, 0.55, 0.7, 0.85};

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        ana     = 0.0;
        start_o = 1'b0;
        ana_o   = 0.0;
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_code", int'(code), 0);
        checkOutput("rst_trial", int'(trial), 0);
        checkOutput("rst_vtrial_uv", $rtoi(vtrial * 1.0e6), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Midscale, threshold edges and out-of-range inputs.
        foreach (directed[i]) begin
            applyStimulus(directed[i]);
            waitDrain();
        end

        // Track-and-hold and ignored start while busy.
        applyStimulus(0.25);
        ana = 0.75;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();
        repeat (5) @(negedge clk);
        checkOutput("hold_code_kept", int'(code), 64);

        // Reset three cycles into a conversion.
        applyStimulus(0.6);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_code", int'(code), 0);
        checkOutput("abort_trial", int'(trial), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(0.3);
        waitDrain();

        // Back-to-back conversions with start held high and a rising ramp.
        @(negedge clk);
        start = 1'b1;
        foreach (ramp[j]) begin
            ana = ramp[j];
            @(negedge clk);
            sb_q.push_back('{refCode(ramp[j], 0.0), edge_cnt});
            ana = real'($urandom_range(0, 1000)) / 1000.0;
            repeat (WIDTH) @(negedge clk);
        end
        start = 1'b0;
        waitDrain();

        // Randomised inputs, including some below zero and above full scale.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(real'($urandom_range(0, 1200000)) / 1.0e6 - 0.1);
            waitDrain();
        end

        // Comparator offset shifts every threshold.
        applyOffsetStimulus(0.5);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_adc.md
# sar_adc

Behavioural successive-approximation ADC for mixed-signal verification: samples a `real` analog input on a start request and resolves it MSB-first against an ideal internal trial DAC, one bit per clock. It is the analog-to-digital counterpart of the team's R-2R DAC models. It closes DAC→ADC loopback benches and feeds digital code streams into downstream RTL.

## Interface
Parameters:
- `WIDTH`, 8, output code width in bits; 2 ≤ `WIDTH` ≤ 16.
- `VREF`, 1.0 (`real`), full-scale reference voltage.
- `COMP_OFFSET`, 0.0 (`real`), comparator input offset in volts, added to every trial voltage.

Ports:
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  conversion request; sampled only in IDLE.
- `ana`  input  `real`  analog input voltage.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when `code` is updated.
- `code`  output  WIDTH  last completed conversion result; held until the next completion.
- `trial`  output  WIDTH  current SAR trial register (debug and coverage).
- `vtrial`  output  `real`  ideal DAC voltage of `trial`: `trial` × `VREF` / 2^`WIDTH`.

## Operation
- LSB = `VREF` / 2^`WIDTH`. Code n spans the input range [n·LSB + `COMP_OFFSET`, (n+1)·LSB + `COMP_OFFSET`).
- States:
  - IDLE to CONV on an edge with `start`=1.
  - CONV to IDLE on the edge that resolves bit 0.
- IDLE accept edge:
  - `v_hold` ← `ana` (track-and-hold; later changes of `ana` are ignored).
  - `trial` ← 1 << (WIDTH-1); `bit_idx` ← WIDTH-1; `busy` ← 1.
- Each CONV edge:
  - Compare `v_hold` ≥ `vtrial` + `COMP_OFFSET`. If false, clear `trial[bit_idx]`.
  - If `bit_idx` > 0: set `trial[bit_idx-1]` and decrement `bit_idx`.
  - If `bit_idx` = 0: `code` ← resolved trial, `done` ← 1, `busy` ← 0, `trial` ← 0, state ← IDLE.
- Out-of-range inputs need no special casing:
  - `ana` < `COMP_OFFSET` resolves to 0.
  - `ana` ≥ `VREF` − LSB + `COMP_OFFSET` resolves to all-ones.
- `start` is ignored while `busy`=1. No queuing and no error flag.
- `start` held high continuously gives back-to-back conversions.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, `busy` 0, `done` 0, `code` 0, `trial` 0, `vtrial` 0.0, internal `v_hold` 0.0.
- Latency: with `start` accepted at edge k, `done` is high for exactly the cycle after edge k+WIDTH. `code` changes at edge k+WIDTH. `busy` is high from edge k to edge k+WIDTH.
- Throughput: one conversion per WIDTH+1 cycles. A `start` seen in the `done` cycle is accepted at edge k+WIDTH+1.
- `vtrial` is recomputed combinationally from `trial` and is valid in the same cycle.
- Reset mid-conversion aborts the conversion. `code` returns to 0 (the last result is not retained) and no `done` pulse is produced.
- `start` asserted in the same cycle as reset deassertion is honoured only on the first edge where `rst`=0.

## Structure
- Package `sar_adc_pkg` holds:
  - `typedef enum logic {IDLE, CONV} sar_state_t`.
  - Function `ideal_dac_v(code, width, vref)`, returning `real`.
  - Function `lsb_v(width, vref)`.
- One sub-module, `sar_comparator`: inputs `vin`, `vref_trial` (`real`), parameter `OFFSET`; output `gt` = (`vin` ≥ `vref_trial` + `OFFSET`). It is combinational and is the hook for later noise or hysteresis models.
- The top module holds the FSM, `v_hold`, `bit_idx` counter, `trial` and `code` registers.

## Test plan
All scenarios use `WIDTH`=8, `VREF`=1.0 (LSB = 0.00390625) unless stated.
- Midscale: `ana`=0.5, pulse `start` → `done` 8 cycles after the accept edge, `code`=128, `busy` high exactly 8 cycles.
- Threshold edges:
  - `ana`=0.49999 → 127.
  - `ana`=0.00390625 → 1.
  - `ana`=0.0039 → 0.
  - `ana`=0.99609375 → 255.
- Out of range: `ana`=−0.2 → 0; `ana`=1.5 → 255.
- Hold and busy behaviour: after the accept, `ana` steps 0.25→0.75 and `start` pulses again mid-conversion → `code`=64, exactly one `done`, the second `start` is ignored.
- Reset mid-conversion: assert `rst` 3 cycles into a conversion → `busy`, `done`, `code`, `trial` all 0 immediately; a new `start` with `ana`=0.3 yields `code`=76.
- Back-to-back and offset:
  - `start` held high with a ramp on `ana` → `done` every 9 cycles with a monotonic `code` sequence.
  - `COMP_OFFSET`=0.01 with `ana`=0.5 → `code`=125.
